// File: rtl/pattern_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pattern_round_ctrl
// Purpose  : Memory-game round sequencer. It fetches a pattern set, plays
//            patterns 0..N-1 to the display, then checks keypad entries.
// Options  : INPUT_TIMEOUT_EN fails the round when INPUT sees no key for
//            TIMEOUT_TICKS cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_round_ctrl #(
    parameter int SHOW_TICKS    = 8,
    parameter int GAP_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  level,
    input  logic [47:0] pat_bus,
    input  logic        gen_done,
    input  logic        key_valid,
    input  logic [2:0]  key_code,
    output logic        gen_enable,
    output logic        disp_on,
    output logic [2:0]  disp_pattern,
    output logic [3:0]  disp_index,
    output logic        busy,
    output logic        round_pass,
    output logic        round_fail,
    output logic [4:0]  score
);

    localparam int c_TICK_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int c_TICK_W   = $clog2(c_TICK_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_SHOW  = 3'd2,
        S_GAP   = 3'd3,
        S_INPUT = 3'd4,
        S_PASS  = 3'd5,
        S_FAIL  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [47:0]           r_store;
    logic [3:0]            r_idx;
    logic [3:0]            r_last;
    logic [4:0]            r_score;
    logic [c_TICK_W-1:0]   r_tick;

    logic [2:0]            w_cur;
    logic                  w_hit;
    logic                  w_last_idx;
    logic                  w_last_show;
    logic                  w_last_gap;
    logic                  w_timeout;

    assign w_cur       = r_store[r_idx*3 +: 3];
    assign w_hit       = (key_code == w_cur);
    assign w_last_idx  = (r_idx == r_last);
    assign w_last_show = (r_tick == c_TICK_W'(SHOW_TICKS - 1));
    assign w_last_gap  = (r_tick == c_TICK_W'(GAP_TICKS - 1));

`ifdef INPUT_TIMEOUT_EN
    logic [15:0] r_idle;

    // Held at zero outside INPUT, so entering INPUT always starts a fresh count.
    always_ff @(posedge clk_1) begin
        if (rst || (r_state != S_INPUT) || key_valid) begin
            r_idle <= 16'd0;
        end else begin
            r_idle <= r_idle + 16'd1;
        end
    end

    assign w_timeout = (r_idle == 16'(TIMEOUT_TICKS - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        gen_enable   = 1'b0;
        disp_on      = 1'b0;
        disp_pattern = 3'd0;
        disp_index   = r_idx;
        busy         = (r_state != S_IDLE);
        round_pass   = 1'b0;
        round_fail   = 1'b0;
        score        = r_score;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_GEN;
            end
            S_GEN: begin
                gen_enable = 1'b1;
                if (gen_done) w_next = S_SHOW;
            end
            S_SHOW: begin
                disp_on      = 1'b1;
                disp_pattern = w_cur;
                if (w_last_show) w_next = S_GAP;
            end
            S_GAP: begin
                if (w_last_gap) w_next = w_last_idx ? S_INPUT : S_SHOW;
            end
            S_INPUT: begin
                // A key in the expiry cycle takes priority over the timeout.
                if (key_valid) begin
                    if (!w_hit)          w_next = S_FAIL;
                    else if (w_last_idx) w_next = S_PASS;
                end else if (w_timeout) begin
                    w_next = S_FAIL;
                end
            end
            S_PASS: begin
                round_pass = 1'b1;
                w_next     = S_IDLE;
            end
            S_FAIL: begin
                round_fail = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_store <= 48'd0;
            r_idx   <= 4'd0;
            r_last  <= 4'd0;
            r_score <= 5'd0;
            r_tick  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last  <= {level, 2'b11};
                        r_score <= 5'd0;
                        r_idx   <= 4'd0;
                        r_tick  <= '0;
                    end
                end
                S_GEN: begin
                    if (gen_done) begin
                        r_store <= pat_bus;
                        r_idx   <= 4'd0;
                        r_tick  <= '0;
                    end
                end
                S_SHOW: begin
                    r_tick <= w_last_show ? '0 : r_tick + 1'b1;
                end
                S_GAP: begin
                    if (w_last_gap) begin
                        r_tick <= '0;
                        r_idx  <= w_last_idx ? 4'd0 : r_idx + 4'd1;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_INPUT: begin
                    if (key_valid && w_hit) begin
                        r_score <= r_score + 5'd1;
                        if (!w_last_idx) r_idx <= r_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_round_ctrl
// Purpose  : Randomized bench; each round is expanded into an expected
//            per-cycle timeline that is replayed and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_round_ctrl;

    localparam int SHOW_TICKS    = 4;
    localparam int GAP_TICKS     = 2;
    localparam int TIMEOUT_TICKS = 16;
`ifdef INPUT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_1 = 1'b0;
    logic        rst, start, gen_done, key_valid;
    logic [1:0]  level;
    logic [47:0] pat_bus;
    logic [2:0]  key_code;
    logic        gen_enable, disp_on, busy, round_pass, round_fail;
    logic [2:0]  disp_pattern;
    logic [3:0]  disp_index;
    logic [4:0]  score;

    always #5 clk_1 = ~clk_1;

    pattern_round_ctrl #(
        .SHOW_TICKS   (SHOW_TICKS),
        .GAP_TICKS    (GAP_TICKS),
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk_1       (clk_1),
        .rst         (rst),
        .start       (start),
        .level       (level),
        .pat_bus     (pat_bus),
        .gen_done    (gen_done),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .gen_enable  (gen_enable),
        .disp_on     (disp_on),
        .disp_pattern(disp_pattern),
        .disp_index  (disp_index),
        .busy        (busy),
        .round_pass  (round_pass),
        .round_fail  (round_fail),
        .score       (score)
    );

    // One cycle: inputs applied during it, outputs expected during it.
    typedef struct {
        logic        rst, start, gd, kv;
        logic [1:0]  level;
        logic [47:0] pat;
        logic [2:0]  kc;
        bit          chk;
        logic        ge, don, bsy, rp, rf;
        logic [2:0]  dp;
        logic [3:0]  di;
        logic [4:0]  sc;
    } cyc_t;

    cyc_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   m_score = 0, m_idx = 0;
    int   obs_pass = 0, obs_fail = 0, obs_don = 0;

    function automatic void check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endfunction

    function automatic cyc_t base(bit noise);
        cyc_t c;
        logic [63:0] r;
        r       = {$urandom(), $urandom()};
        c.rst   = 1'b0;
        c.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        c.gd    = 1'($urandom_range(0, 1));
        c.kv    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        c.level = 2'($urandom_range(0, 3));
        c.pat   = r[47:0];
        c.kc    = 3'($urandom_range(0, 7));
        c.chk   = 1'b1;
        c.ge    = 1'b0; c.don = 1'b0; c.bsy = 1'b0; c.rp = 1'b0; c.rf = 1'b0;
        c.dp    = 3'd0;
        c.di    = 4'(m_idx);
        c.sc    = 5'(m_score);
        return c;
    endfunction

    task automatic add_idle(input int n, input bit noise);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = base(noise);
            c.start = 1'b0;
            q.push_back(c);
        end
    endtask

    task automatic add_end(input bit pass, input bit noise);
        cyc_t c;
        c = base(noise);
        c.bsy = 1'b1;
        if (pass) c.rp = 1'b1; else c.rf = 1'b1;
        q.push_back(c);
    endtask

    task automatic add_round(input logic [1:0] lvl, input logic [47:0] store, input int gwait,
                             input logic [2:0] keys[16], input int waits[16], input bit noise);
        cyc_t c;
        int   n;
        n = 4 * (int'(lvl) + 1);
        c = base(noise);
        c.start = 1'b1;
        c.level = lvl;
        q.push_back(c);
        m_score = 0;
        m_idx   = 0;
        for (int i = 0; i <= gwait; i++) begin
            c = base(noise);
            c.ge = 1'b1; c.bsy = 1'b1;
            c.gd = (i == gwait);
            if (i == gwait) c.pat = store;
            q.push_back(c);
        end
        for (int k = 0; k < n; k++) begin
            m_idx = k;
            for (int t = 0; t < SHOW_TICKS + GAP_TICKS; t++) begin
                c = base(noise);
                c.bsy = 1'b1;
                if (t < SHOW_TICKS) begin
                    c.don = 1'b1;
                    c.dp  = store[3*k +: 3];
                end
                q.push_back(c);
            end
        end
        m_idx = 0;
        for (int j = 0; j < n; j++) begin
            int idle;
            bit to;
            to   = TO_EN && (waits[j] >= TIMEOUT_TICKS);
            idle = to ? TIMEOUT_TICKS : waits[j];
            for (int t = 0; t < idle; t++) begin
                c = base(noise);
                c.bsy = 1'b1; c.kv = 1'b0;
                q.push_back(c);
            end
            if (to) begin
                add_end(1'b0, noise);
                return;
            end
            c = base(noise);
            c.bsy = 1'b1; c.kv = 1'b1; c.kc = keys[j];
            q.push_back(c);
            if (keys[j] != store[3*j +: 3]) begin
                add_end(1'b0, noise);
                return;
            end
            m_score++;
            if (j == n - 1) begin
                add_end(1'b1, noise);
                return;
            end
            m_idx++;
        end
    endtask

    // Assert reset on the last kept cycle and expect a clean IDLE afterwards.
    task automatic cut_with_reset(input int cut);
        while (q.size() > cut) void'(q.pop_back());
        q[cut-1].rst = 1'b1;
        m_score = 0;
        m_idx   = 0;
        add_idle(2, 1'b1);
    endtask

    task automatic run_queue();
        int t;
        t = 0;
        while (q.size() != 0 && t < 20000) begin
            @(posedge clk_1);
            t++;
        end
        if (q.size() != 0) begin
            $display("FAIL queue_drain: %0d cycles left, expected 0", q.size());
            $fatal(1, "timeline did not drain");
        end
        @(negedge clk_1);
        @(negedge clk_1);
    endtask

    always @(negedge clk_1) begin
        cyc_t c;
        if (round_pass === 1'b1) obs_pass++;
        if (round_fail === 1'b1) obs_fail++;
        if (disp_on === 1'b1)    obs_don++;
        if (q.size() != 0) begin
            c = q.pop_front();
            if (c.chk) begin
                check("gen_enable",   int'(gen_enable),   int'(c.ge));
                check("disp_on",      int'(disp_on),      int'(c.don));
                check("disp_pattern", int'(disp_pattern), int'(c.dp));
                check("disp_index",   int'(disp_index),   int'(c.di));
                check("busy",         int'(busy),         int'(c.bsy));
                check("round_pass",   int'(round_pass),   int'(c.rp));
                check("round_fail",   int'(round_fail),   int'(c.rf));
                check("score",        int'(score),        int'(c.sc));
            end
            rst = c.rst; start = c.start; level = c.level; pat_bus = c.pat;
            gen_done = c.gd; key_valid = c.kv; key_code = c.kc;
        end else begin
            rst = 1'b0; start = 1'b0; gen_done = 1'b0; key_valid = 1'b0;
        end
    end

    task automatic clear_obs();
        obs_pass = 0; obs_fail = 0; obs_don = 0;
    endtask

    initial begin
        cyc_t        c;
        logic [2:0]  keys[16];
        int          waits[16];
        logic [47:0] store;
        logic [63:0] r;
        int          len0, cut;

        rst = 1'b1; start = 1'b0; level = 2'd0; pat_bus = 48'd0;
        gen_done = 1'b0; key_valid = 1'b0; key_code = 3'd0;

        c = base(1'b0);
        c.rst = 1'b1; c.chk = 1'b0;
        q.push_back(c);
        add_idle(3, 1'b0);
        run_queue();

        // Level 0, patterns 3,5,0,7; upper store entries must be ignored.
        store = {36'hFA5_C3E_917, 12'b111_000_101_011};
        keys[0] = 3'd3; keys[1] = 3'd5; keys[2] = 3'd0; keys[3] = 3'd7;
        for (int i = 0; i < 16; i++) waits[i] = i % 3;
        clear_obs();
        add_round(2'd0, store, 2, keys, waits, 1'b0);
        add_idle(3, 1'b0);
        run_queue();
        check("l0_pass_score", int'(score), 4);
        check("l0_pass_pulses", obs_pass, 1);
        check("l0_show_cycles", obs_don, 16);
        check("l0_fail_pulses", obs_fail, 0);

        keys[1] = 3'd6;
        clear_obs();
        add_round(2'd0, store, 2, keys, waits, 1'b0);
        add_idle(3, 1'b0);
        run_queue();
        check("l0_fail_score", int'(score), 1);
        check("l0_fail_pulses2", obs_fail, 1);
        check("l0_fail_busy", int'(busy), 0);
        check("l0_fail_index", int'(disp_index), 1);

        // Level 3 with start/key noise during show and input.
        r = {$urandom(), $urandom()};
        store = r[47:0];
        for (int i = 0; i < 16; i++) keys[i] = store[3*i +: 3];
        clear_obs();
        add_round(2'd3, store, 1, keys, waits, 1'b1);
        add_idle(3, 1'b0);
        run_queue();
        check("l3_score", int'(score), 16);
        check("l3_show_cycles", obs_don, 16 * SHOW_TICKS);
        check("l3_pass_pulses", obs_pass, 1);

        // Reset while the third SHOW cycle is displayed.
        clear_obs();
        len0 = q.size();
        add_round(2'd1, store, 0, keys, waits, 1'b0);
        cut_with_reset(len0 + 1 + 1 + 3);
        run_queue();
        check("rst_show_score", int'(score), 0);
        check("rst_show_busy", int'(busy), 0);
        check("rst_show_pulses", obs_pass + obs_fail, 0);

        if (TO_EN) begin
            for (int i = 0; i < 16; i++) waits[i] = 0;
            waits[0] = TIMEOUT_TICKS;
            clear_obs();
            add_round(2'd0, store, 0, keys, waits, 1'b0);
            add_idle(2, 1'b0);
            run_queue();
            check("timeout_fail", obs_fail, 1);
            waits[0] = TIMEOUT_TICKS - 1;
            clear_obs();
            add_round(2'd0, store, 0, keys, waits, 1'b0);
            add_idle(2, 1'b0);
            run_queue();
            check("late_key_pass", obs_pass, 1);
            check("late_key_nofail", obs_fail, 0);
        end

        for (int rnd = 0; rnd < 40; rnd++) begin
            r = {$urandom(), $urandom()};
            store = r[47:0];
            for (int j = 0; j < 16; j++) begin
                keys[j] = store[3*j +: 3];
                if ($urandom_range(0, 24) == 0) keys[j] = keys[j] ^ 3'($urandom_range(1, 7));
                waits[j] = $urandom_range(0, 4);
                if (TO_EN && $urandom_range(0, 9) == 0)
                    waits[j] = TIMEOUT_TICKS - 1 + $urandom_range(0, 1);
            end
            len0 = q.size();
            add_round(2'($urandom_range(0, 3)), store, $urandom_range(0, 5), keys, waits, 1'b1);
            if ($urandom_range(0, 5) == 0) begin
                cut = len0 + $urandom_range(1, q.size() - len0);
                cut_with_reset(cut);
            end else begin
                add_idle($urandom_range(1, 3), 1'b1);
            end
            run_queue();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
